// File: rtl/rtl_settings_pkg.sv
// Shared settings for the measurement slice.
// Holds the drain length used by the result processor, its FSM state
// encoding and the packed snapshot of the raw measurement counters.
package rtl_settings_pkg;

  // Consecutive idle cycles of the measurement block before counters are frozen
  localparam int MEAS_DRAIN_CYC = 4;

  // Width of every raw measurement counter
  localparam int MEAS_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN,
    ST_DIV_DLY,
    ST_DIV_BRST,
    ST_DONE
  } meas_proc_state_t;

  typedef struct packed {
    logic [MEAS_CNT_W-1:0] wr_ticks;
    logic [MEAS_CNT_W-1:0] wr_units;
    logic [MEAS_CNT_W-1:0] rd_ticks;
    logic [MEAS_CNT_W-1:0] rd_words;
    logic [MEAS_CNT_W-1:0] min_max_delay;
    logic [MEAS_CNT_W-1:0] sum_delay;
    logic [MEAS_CNT_W-1:0] rd_req_amount;
  } meas_snapshot_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider, one quotient bit per cycle.
// A start is accepted only while idle (including the cycle done is high);
// done pulses DIV_W+1 cycles after the start cycle with the quotient
// valid on quotient_o. clear_i aborts any division in progress.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   clear_i                 synchronous abort
//   start_i                 begin a division with dividend_i / divisor_i
//   quotient_o              truncated quotient (remainder is discarded)
//   busy_o, done_o          division running / one-cycle completion pulse
module seq_divider #(
  parameter int DIV_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [DIV_W-1:0] quotient_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   trial;
  logic             fits;
  logic [DIV_W-1:0] rem_next;

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction; the borrow bit of the trial tells whether it fits.
  always_comb begin
    shifted  = {rem_q, quotient_o[DIV_W-1]};
    trial    = shifted - {1'b0, divisor_q};
    fits     = ~trial[DIV_W];
    rem_next = fits ? trial[DIV_W-1:0] : shifted[DIV_W-1:0];
  end

  // quotient_o doubles as the dividend shift register: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q      <= '0;
      divisor_q  <= '0;
      quotient_o <= '0;
      cnt_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i && !busy_o) begin
        rem_q      <= '0;
        divisor_q  <= divisor_i;
        quotient_o <= dividend_i;
        cnt_q      <= CNT_W'(DIV_W);
        busy_o     <= 1'b1;
      end else if (busy_o) begin
        rem_q      <= rem_next;
        quotient_o <= {quotient_o[DIV_W-2:0], fits};
        cnt_q      <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/meas_result_proc.sv
// Result processor downstream of the measurement block.
// After the test controller reports the last transaction and the
// measurement block has been idle for DRAIN_CYC cycles, all raw counters
// are frozen; one shared divider then computes the average read delay and
// the average read burst length. Results are held with result_valid_o
// until the next start_test_i.
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   start_test_i                   abort and re-arm (highest priority)
//   test_done_i                    last transaction issued
//   meas_busy_i                    measurement block still has reads in flight
//   *_i counters                   raw counters, frozen into the *_o copies
//   avg_delay_o, avg_burst_o       truncated averages
//   div_zero_o                     frozen request count was zero
//   result_valid_o, proc_busy_o    results final / block armed or computing
module meas_result_proc
  import rtl_settings_pkg::*;
#(
  parameter int DIV_W     = 32,
  parameter int DRAIN_CYC = MEAS_DRAIN_CYC
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_test_i,
  input  logic             test_done_i,
  input  logic             meas_busy_i,
  input  logic [31:0]      wr_ticks_i,
  input  logic [31:0]      wr_units_i,
  input  logic [31:0]      rd_ticks_i,
  input  logic [31:0]      rd_words_i,
  input  logic [31:0]      min_max_delay_i,
  input  logic [31:0]      sum_delay_i,
  input  logic [31:0]      rd_req_amount_i,
  output logic [31:0]      wr_ticks_o,
  output logic [31:0]      wr_units_o,
  output logic [31:0]      rd_ticks_o,
  output logic [31:0]      rd_words_o,
  output logic [31:0]      min_max_delay_o,
  output logic [31:0]      sum_delay_o,
  output logic [31:0]      rd_req_amount_o,
  output logic [DIV_W-1:0] avg_delay_o,
  output logic [DIV_W-1:0] avg_burst_o,
  output logic             div_zero_o,
  output logic             result_valid_o,
  output logic             proc_busy_o
);

  localparam int               CNT_W      = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

  meas_proc_state_t state;
  logic [CNT_W-1:0] drain_cnt;
  meas_snapshot_t   snap_q;
  meas_snapshot_t   snap_in;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_divisor;
  logic [DIV_W-1:0] div_quotient;

  assign snap_in = '{wr_ticks:      wr_ticks_i,
                     wr_units:      wr_units_i,
                     rd_ticks:      rd_ticks_i,
                     rd_words:      rd_words_i,
                     min_max_delay: min_max_delay_i,
                     sum_delay:     sum_delay_i,
                     rd_req_amount: rd_req_amount_i};

  assign wr_ticks_o      = snap_q.wr_ticks;
  assign wr_units_o      = snap_q.wr_units;
  assign rd_ticks_o      = snap_q.rd_ticks;
  assign rd_words_o      = snap_q.rd_words;
  assign min_max_delay_o = snap_q.min_max_delay;
  assign sum_delay_o     = snap_q.sum_delay;
  assign rd_req_amount_o = snap_q.rd_req_amount;

  // The delay division starts on the first DIV_DLY cycle (divider idle).
  // The burst division is chained into the cycle where the delay division
  // reports done, so the divider never sits idle between the two.
  always_comb begin
    div_start    = (state == ST_DIV_DLY) && !div_zero_o && !div_busy;
    div_dividend = div_done ? DIV_W'(snap_q.rd_words) : DIV_W'(snap_q.sum_delay);
    div_divisor  = DIV_W'(snap_q.rd_req_amount);
  end

  seq_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (start_test_i),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .quotient_o (div_quotient),
    .busy_o     (div_busy),
    .done_o     (div_done)
  );

  // Control FSM with registered status outputs; start_test_i overrides
  // every state and wipes the derived results but keeps the old snapshot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      drain_cnt      <= '0;
      snap_q         <= '0;
      avg_delay_o    <= '0;
      avg_burst_o    <= '0;
      div_zero_o     <= 1'b0;
      result_valid_o <= 1'b0;
      proc_busy_o    <= 1'b0;
    end else if (start_test_i) begin
      state          <= ST_ARMED;
      drain_cnt      <= '0;
      avg_delay_o    <= '0;
      avg_burst_o    <= '0;
      div_zero_o     <= 1'b0;
      result_valid_o <= 1'b0;
      proc_busy_o    <= 1'b1;
    end else begin
      case (state)
        ST_ARMED: begin
          if (test_done_i) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          // Any busy cycle restarts the idle window from scratch
          if (meas_busy_i) begin
            drain_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            snap_q      <= snap_in;
            div_zero_o  <= (rd_req_amount_i == '0);
            avg_delay_o <= '0;
            avg_burst_o <= '0;
            drain_cnt   <= '0;
            state       <= ST_DIV_DLY;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        ST_DIV_DLY: begin
          if (div_zero_o) begin
            state <= ST_DIV_BRST;
          end else if (div_done) begin
            avg_delay_o <= div_quotient;
            state       <= ST_DIV_BRST;
          end
        end
        ST_DIV_BRST: begin
          if (div_zero_o || div_done) begin
            if (!div_zero_o) begin
              avg_burst_o <= div_quotient;
            end
            result_valid_o <= 1'b1;
            proc_busy_o    <= 1'b0;
            state          <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          state <= state;
        end
        default: begin
          state       <= ST_IDLE;
          proc_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
